mux_sel_scan: RTL and testbench
===============================

Name: mux_sel_scan

Overview:
- Select-sequencer that generates the 2-bit select S for the downstream 4:1 one-bit multiplexer.
- Scans the enabled channels (a..d = 00..11) in ascending circular order.
- Holds each channel for a programmable dwell time.
- Supports one-shot and continuous scanning, with a frame-complete pulse and a graceful stop request.

Parameters:
DWELL_W, 8, width of the dwell-count input and the internal dwell counter

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-high reset
start  input  1  begin a scan; sampled only in IDLE
mode  input  1  0 = one-shot (single frame), 1 = continuous
mask  input  4  channel enable; bit i enables channel S=i
dwell  input  DWELL_W  cycles per channel; 0 is treated as 1
stop  input  1  continuous mode only: finish the current frame, then return to IDLE
S  output reg  2  select to the mux
valid  output reg  1  S points at an enabled channel in an active dwell
busy  output reg  1  scan in progress
frame_done  output reg  1  one-cycle pulse at the end of each frame

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high. While reset=1, all outputs are held at their reset values.
- Reset values: S=2'b00, valid=0, busy=0, frame_done=0, state=IDLE, dwell counter=0, stop flag=0, captured mask/dwell/mode=0.
- Reset mid-scan: S, valid, busy and frame_done go to their reset values immediately (no clock edge needed). No frame_done pulse is produced.
- States: IDLE and DWELL.
- Effective dwell: D = (dwell==0) ? 1 : dwell.
- Next channel function: next(x) is the first set bit of the captured mask searched x+1, x+2, x+3, x (mod 4). It wraps. If only one bit is set, next(x) = x.
- "Last" channel: the highest-index set bit of the captured mask.
- "First" channel: the lowest-index set bit of the captured mask.
- IDLE, start=1 and mask!=0, at the sampling edge:
  - capture mask, D and mode
  - S <= first, counter <= 1, valid <= 1, busy <= 1
  - clear the stop flag, go to DWELL
- IDLE, start=1 and mask==0: start is ignored; all outputs unchanged.
- IDLE, stop: ignored.
- DWELL, counter < D: counter increments; S holds.
  - Result: each channel is presented with valid=1 for exactly D consecutive cycles.
- DWELL, counter == D and S != last: S <= next(S), counter <= 1.
- DWELL, counter == D and S == last (frame end): frame_done <= 1 for exactly one cycle.
  - Continuous mode, stop flag clear: S <= first, counter <= 1, stay in DWELL. No gap cycle between frames.
  - One-shot mode, or stop flag set: go to IDLE; valid <= 0, busy <= 0; S holds the last channel.
- Stop flag: set by stop=1 on any DWELL cycle. Cleared only by reset or by a new start.
  - A stop arriving on the frame-end cycle itself takes effect at that frame end.
- While busy: start, mask, dwell and mode inputs are ignored. The captured copies govern the scan.
- frame_done is a pulse only. It is 0 on every cycle except the one following each frame-end edge.
- All outputs are registered. There is no combinational path from any input to any output.

Test Plan:
1. Reset mid-scan: reset pulses during the DWELL of channel 10 -> S=00, valid=0, busy=0 asynchronously, before the next clk edge; no frame_done.
2. One-shot: mask=4'b1111, dwell=3, mode=0, start pulse.
   - Required: S=00,01,10,11, each for 3 cycles with valid=1 (12 cycles total).
   - Then valid=0, busy=0, S=11, and frame_done=1 on exactly the first IDLE cycle.
3. Sparse mask, continuous: mask=4'b1010, dwell=0, mode=1.
   - Required: S alternates 01,11,01,11,... every cycle.
   - frame_done=1 on each cycle where S returns to 01 after 11.
   - Assert stop during any cycle -> scan ends after the next 11 dwell; busy=0.
4. Single channel, continuous: mask=4'b0100, dwell=2, mode=1.
   - Required: S=10 constant, valid=1 constant, frame_done pulses every 2 cycles.
5. Ignored inputs:
   - start with mask=0 -> busy stays 0.
   - Change mask to 4'b0001 and dwell to 9 mid-scan of case 2 -> sequence and timing unchanged.
   - start pulse while busy -> no restart.

Source files
------------

// File: rtl/mux_sel_scan.sv
// mux_sel_scan: select sequencer driving S of a downstream 4:1 one-bit mux.
// Scans the enabled channels in ascending circular order, dwelling on each
// for a programmable number of cycles, in one-shot or continuous mode.
module mux_sel_scan #(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic [3:0]         mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               stop,
  output logic [1:0]         S,
  output logic               valid,
  output logic               busy,
  output logic               frame_done
);

  typedef enum logic {IDLE = 1'b0, DWELL = 1'b1} state_t;

  state_t             state;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] cap_dwell;
  logic [3:0]         cap_mask;
  logic               cap_mode;
  logic               stop_flag;

  logic [1:0]         first_ch;
  logic [1:0]         last_ch;
  logic [1:0]         next_ch;
  logic [1:0]         start_ch;
  logic [DWELL_W-1:0] start_dwell;
  logic               dwell_end;
  logic               stop_now;

  // Lowest set bit of m (0 when m is empty).
  function automatic logic [1:0] first_set(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) r = 2'(i);
    end
    return r;
  endfunction

  // Highest set bit of m (0 when m is empty).
  function automatic logic [1:0] last_set(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) r = 2'(i);
    end
    return r;
  endfunction

  // First set bit searching x+1, x+2, x+3 (mod 4); falls back to x itself.
  function automatic logic [1:0] next_set(input logic [3:0] m, input logic [1:0] x);
    logic [1:0] r;
    logic [1:0] idx;
    r = x;
    for (int k = 3; k >= 1; k--) begin
      idx = x + 2'(k);
      if (m[idx]) r = idx;
    end
    return r;
  endfunction

  // Channel selection helpers and dwell-end detection.
  always_comb begin
    first_ch    = first_set(cap_mask);
    last_ch     = last_set(cap_mask);
    next_ch     = next_set(cap_mask, S);
    start_ch    = first_set(mask);
    start_dwell = (dwell == '0) ? DWELL_W'(1) : dwell;
    dwell_end   = (cnt == cap_dwell);
    // a stop seen on the frame-end cycle itself still ends this frame
    stop_now    = stop_flag | stop;
  end

  // Scan state machine with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      cap_dwell  <= '0;
      cap_mask   <= 4'd0;
      cap_mode   <= 1'b0;
      stop_flag  <= 1'b0;
      S          <= 2'd0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && (mask != 4'd0)) begin
            cap_mask  <= mask;
            cap_dwell <= start_dwell;
            cap_mode  <= mode;
            stop_flag <= 1'b0;
            S         <= start_ch;
            cnt       <= DWELL_W'(1);
            valid     <= 1'b1;
            busy      <= 1'b1;
            state     <= DWELL;
          end
        end
        DWELL: begin
          if (stop) stop_flag <= 1'b1;
          if (!dwell_end) begin
            cnt <= cnt + DWELL_W'(1);
          end else if (S != last_ch) begin
            S   <= next_ch;
            cnt <= DWELL_W'(1);
          end else begin
            frame_done <= 1'b1;
            if (cap_mode && !stop_now) begin
              S   <= first_ch;
              cnt <= DWELL_W'(1);
            end else begin
              valid <= 1'b0;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_sel_scan.sv
// Directed, table-driven bench for mux_sel_scan.
module tb_mux_sel_scan;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       mode;
  logic [3:0] mask;
  logic [7:0] dwell;
  logic       stop;
  logic [1:0] S;
  logic       valid;
  logic       busy;
  logic       frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  mux_sel_scan #(.DWELL_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .mask(mask),
    .dwell(dwell), .stop(stop), .S(S), .valid(valid), .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       mode;
    logic       stop;
    logic [3:0] mask;
    logic [7:0] dwell;
    logic [1:0] s;
    logic       valid;
    logic       busy;
    logic       fd;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input logic st, input logic md, input logic sp,
                              input logic [3:0] mk_mask, input logic [7:0] dw,
                              input logic [1:0] s, input logic v, input logic b,
                              input logic f);
    vec_t r;
    r.start = st; r.mode = md; r.stop = sp; r.mask = mk_mask; r.dwell = dw;
    r.s = s; r.valid = v; r.busy = b; r.fd = f;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_out(input string name, input logic [1:0] s, input logic v,
                         input logic b, input logic f);
    chk({name, ".S"}, 8'(S), 8'(s));
    chk({name, ".valid"}, 8'(valid), 8'(v));
    chk({name, ".busy"}, 8'(busy), 8'(b));
    chk({name, ".frame_done"}, 8'(frame_done), 8'(f));
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      tick();
      k++;
    end
    n_cmp++;
    if (busy) begin
      n_bad++;
      $display("FAIL %s: busy still 1 after %0d cycles, expected 0", name, budget);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 1'b0; mask = 4'd0; dwell = 8'd0; stop = 1'b0;

    // one-shot full mask, dwell 3, with ignored mid-scan changes and idle checks
    tbl[0]  = mk(1, 0, 0, 4'hF, 8'd3, 2'd0, 1, 1, 0);
    tbl[1]  = mk(0, 0, 0, 4'hF, 8'd3, 2'd0, 1, 1, 0);
    tbl[2]  = mk(0, 0, 0, 4'hF, 8'd3, 2'd0, 1, 1, 0);
    tbl[3]  = mk(0, 0, 0, 4'hF, 8'd3, 2'd1, 1, 1, 0);
    tbl[4]  = mk(1, 1, 0, 4'h1, 8'd9, 2'd1, 1, 1, 0);
    tbl[5]  = mk(0, 1, 0, 4'h1, 8'd9, 2'd1, 1, 1, 0);
    tbl[6]  = mk(0, 0, 0, 4'h1, 8'd9, 2'd2, 1, 1, 0);
    tbl[7]  = mk(0, 0, 0, 4'h1, 8'd9, 2'd2, 1, 1, 0);
    tbl[8]  = mk(0, 0, 0, 4'h1, 8'd9, 2'd2, 1, 1, 0);
    tbl[9]  = mk(0, 0, 0, 4'h1, 8'd9, 2'd3, 1, 1, 0);
    tbl[10] = mk(0, 0, 0, 4'h1, 8'd9, 2'd3, 1, 1, 0);
    tbl[11] = mk(0, 0, 0, 4'h1, 8'd9, 2'd3, 1, 1, 0);
    tbl[12] = mk(0, 0, 0, 4'h1, 8'd9, 2'd3, 0, 0, 1);
    tbl[13] = mk(0, 0, 0, 4'h1, 8'd9, 2'd3, 0, 0, 0);
    tbl[14] = mk(1, 0, 0, 4'h0, 8'd3, 2'd3, 0, 0, 0);
    tbl[15] = mk(0, 0, 1, 4'h0, 8'd3, 2'd3, 0, 0, 0);

    // reset state
    #12;
    chk_out("reset", 2'd0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      start = tbl[i].start; mode = tbl[i].mode; stop = tbl[i].stop;
      mask = tbl[i].mask; dwell = tbl[i].dwell;
      tick();
      chk_out($sformatf("oneshot[%0d]", i), tbl[i].s, tbl[i].valid, tbl[i].busy, tbl[i].fd);
    end
    start = 1'b0; stop = 1'b0;

    // sparse mask continuous, dwell 0 acts as 1; stop on a non-final cycle
    mask = 4'b1010; dwell = 8'd0; mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; mask = 4'd0;
    chk_out("sparse[0]", 2'd1, 1, 1, 0);
    for (int i = 1; i < 6; i++) begin
      tick();
      chk_out($sformatf("sparse[%0d]", i), (i % 2 == 0) ? 2'd1 : 2'd3, 1, 1,
              (i % 2 == 0) ? 1'b1 : 1'b0);
    end
    // now at S=11; next edge returns to 01, then raise stop during the 01 cycle
    tick();
    chk_out("sparse[6]", 2'd1, 1, 1, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_out("sparse_stop_a", 2'd3, 1, 1, 0);
    tick();
    chk_out("sparse_stop_b", 2'd3, 0, 0, 1);
    tick();
    chk_out("sparse_idle", 2'd3, 0, 0, 0);

    // single channel continuous, dwell 2; stop raised on the frame-end cycle
    mask = 4'b0100; dwell = 8'd2; mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("single[0]", 2'd2, 1, 1, 0);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk_out($sformatf("single[%0d]", i), 2'd2, 1, 1, (i % 2 == 0) ? 1'b1 : 1'b0);
    end
    // counter now 2 (frame-end cycle): stop takes effect at this edge
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_out("single_stop", 2'd2, 0, 0, 1);
    wait_idle("single_idle", 4);

    // reset mid-scan during channel 10
    mask = 4'hF; dwell = 8'd3; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk_out("pre_reset", 2'd2, 1, 1, 0);
    #2;
    reset = 1'b1;
    #1;
    chk_out("async_reset", 2'd0, 0, 0, 0);
    tick();
    chk_out("reset_held", 2'd0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk_out("after_reset", 2'd0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
